// File: rtl/synth_pkg.sv
// Shared constants for the synth voice path: octave-0 period table at 50 MHz,
// allocator FSM encoding and default sizing.
package synth_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int NOTE_W_DEF     = 7;
  localparam int PERIOD_W_DEF   = 32;

  // A 7-bit note reduces to rem 0..11 and octave 0..10.
  localparam int REM_W = 4;
  localparam int OCT_W = 4;

  // Periods in clk cycles for MIDI notes 0..11 (A = 13.75 Hz at index 9), rounded.
  localparam int unsigned BASE_PERIOD [0:11] = '{
    6115610, 5772367, 5448389, 5142595, 4853963, 4581531,
    4324390, 4081680, 3852593, 3636364, 3432270, 3239632
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ALLOC = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/note_period_rom.sv
// Combinational note-to-period lookup: octave-0 base period shifted down by octave.
module note_period_rom
  import synth_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic [REM_W-1:0]    rem,
  input  logic [OCT_W-1:0]    oct,
  output logic [PERIOD_W-1:0] period
);

  logic [31:0] base_period;
  logic [31:0] shifted_period;

  // Out-of-table remainders only occur mid-division and are never consumed.
  always_comb begin
    base_period = 32'd0;
    if (rem < REM_W'(12)) begin
      base_period = BASE_PERIOD[rem];
    end
  end

  assign shifted_period = base_period >> oct;
  assign period         = PERIOD_W'(shifted_period);

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note events in, per-voice period/gate/load out,
// with retrigger, lowest-free and least-recently-assigned stealing.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int PERIOD_W   = PERIOD_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_on,
  input  logic [NOTE_W-1:0]              ev_note,
  output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  output logic [NUM_VOICES-1:0]          voice_gate,
  output logic [NUM_VOICES-1:0]          voice_load,
  output logic                           steal_evt
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  alloc_state_t        state_reg, state_next;
  logic                on_reg, on_next;
  logic [NOTE_W-1:0]   note_reg, note_next;
  logic [NOTE_W-1:0]   rem_reg, rem_next;
  logic [OCT_W-1:0]    oct_reg, oct_next;
  logic [PERIOD_W-1:0] new_period;

  logic [NUM_VOICES-1:0] match_vec, free_vec, oldest_vec;
  logic [VIDX_W-1:0]     rank_arr [NUM_VOICES];
  logic [VIDX_W-1:0]     hit_idx, free_idx, old_idx, pick_idx;
  logic                  hit_any, free_any, do_alloc, steal_now;
  logic                  steal_reg;

  assign ev_ready = reset && (state_reg == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      on_reg    <= 1'b0;
      note_reg  <= '0;
      rem_reg   <= '0;
      oct_reg   <= '0;
      steal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      on_reg    <= on_next;
      note_reg  <= note_next;
      rem_reg   <= rem_next;
      oct_reg   <= oct_next;
      steal_reg <= steal_now;
    end
  end

  // Octave extraction by repeated subtraction of 12, one step per cycle.
  always_comb begin
    state_next = state_reg;
    on_next    = on_reg;
    note_next  = note_reg;
    rem_next   = rem_reg;
    oct_next   = oct_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ev_valid && ev_ready) begin
          on_next    = ev_on;
          note_next  = ev_note;
          rem_next   = ev_note;
          oct_next   = '0;
          state_next = ev_on ? ST_DIV : ST_ALLOC;
        end
      end
      ST_DIV: begin
        if (rem_reg >= NOTE_W'(12)) begin
          rem_next = rem_reg - NOTE_W'(12);
          oct_next = oct_reg + OCT_W'(1);
        end else begin
          state_next = ST_ALLOC;
        end
      end
      ST_ALLOC: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  note_period_rom #(.PERIOD_W(PERIOD_W)) u_rom (
    .rem    (rem_reg[REM_W-1:0]),
    .oct    (oct_reg),
    .period (new_period)
  );

  // Scanning high-to-low leaves the lowest matching index.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (match_vec[i])  hit_idx  = VIDX_W'(i);
      if (free_vec[i])   free_idx = VIDX_W'(i);
      if (oldest_vec[i]) old_idx  = VIDX_W'(i);
    end
  end

  assign hit_any   = |match_vec;
  assign free_any  = |free_vec;
  assign do_alloc  = (state_reg == ST_ALLOC);
  assign steal_now = do_alloc && on_reg && !hit_any && !free_any;

  always_comb begin
    pick_idx = hit_idx;
    if (on_reg && !hit_any) begin
      pick_idx = free_any ? free_idx : old_idx;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic [PERIOD_W-1:0] period_reg;
      logic [NOTE_W-1:0]   note_v_reg;
      logic [VIDX_W-1:0]   rank_reg;
      logic                gate_reg, load_reg;
      logic                picked, on_write, off_clear, age_bump;

      assign picked    = (pick_idx == VIDX_W'(gi));
      assign on_write  = do_alloc && on_reg && picked;
      assign off_clear = do_alloc && !on_reg && hit_any && picked;
      assign age_bump  = do_alloc && on_reg && (rank_reg < rank_arr[pick_idx]);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          period_reg <= '0;
          note_v_reg <= '0;
          rank_reg   <= VIDX_W'(gi);
          gate_reg   <= 1'b0;
          load_reg   <= 1'b0;
        end else begin
          load_reg <= on_write;
          if (on_write) begin
            period_reg <= new_period;
            note_v_reg <= note_reg;
            gate_reg   <= 1'b1;
            rank_reg   <= '0;
          end else if (age_bump) begin
            rank_reg <= rank_reg + VIDX_W'(1);
          end
          if (off_clear) begin
            gate_reg <= 1'b0;
          end
        end
      end

      assign match_vec[gi]  = gate_reg && (note_v_reg == note_reg);
      assign free_vec[gi]   = !gate_reg;
      assign oldest_vec[gi] = (rank_reg == VIDX_W'(NUM_VOICES - 1));
      assign rank_arr[gi]   = rank_reg;

      assign voice_period[gi*PERIOD_W +: PERIOD_W] = period_reg;
      assign voice_gate[gi] = gate_reg;
      assign voice_load[gi] = load_reg;
    end
  endgenerate

  assign steal_evt = steal_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: hand-computed periods, voice choices and latencies.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int NW = 7;
  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_on = 1'b0;
  logic [NW-1:0]   ev_note = '0;
  logic [NV*PW-1:0] voice_period;
  logic [NV-1:0]   voice_gate;
  logic [NV-1:0]   voice_load;
  logic            steal_evt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_per [NV];
  logic seen;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .PERIOD_W(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .voice_period (voice_period),
    .voice_gate   (voice_gate),
    .voice_load   (voice_load),
    .steal_evt    (steal_evt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NV*PW-1:0] exp_periods();
    logic [NV*PW-1:0] p;
    for (int i = 0; i < NV; i++) p[i*PW +: PW] = exp_per[i];
    return p;
  endfunction

  task automatic note_on(input logic [NW-1:0] note, input int exp_voice, input logic exp_steal);
    int edges;
    logic got;
    @(negedge clk);
    check("on_ready_idle", ev_ready, 1);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = note;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    check("on_ready_busy", ev_ready, 0);
    edges = 0;
    got = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (voice_load != '0) got = 1'b1;
    end
    $display("note_on %0d: load=%b steal=%b edges=%0d gate=%b", note, voice_load, steal_evt, edges, voice_gate);
    check("on_latency", edges, int'(note) / 12 + 2);
    check("on_load", voice_load, 128'(1) << exp_voice);
    check("on_steal", steal_evt, exp_steal);
    check("on_ready_after", ev_ready, 1);
    @(posedge clk); #1;
    check("on_load_one_cycle", voice_load, 0);
    check("on_steal_one_cycle", steal_evt, 0);
  endtask

  task automatic note_off(input logic [NW-1:0] note);
    @(negedge clk);
    check("off_ready_idle", ev_ready, 1);
    ev_valid = 1'b1; ev_on = 1'b0; ev_note = note;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    check("off_ready_busy", ev_ready, 0);
    @(posedge clk); #1;
    $display("note_off %0d: gate=%b load=%b ready=%b", note, voice_gate, voice_load, ev_ready);
    check("off_ready_after", ev_ready, 1);
    check("off_no_load", voice_load, 0);
    check("off_no_steal", steal_evt, 0);
  endtask

  task automatic reset_mid_div();
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd100;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    $display("reset mid-DIV: period=%0h gate=%b ready=%b", voice_period, voice_gate, ev_ready);
    check("rst_period", voice_period, 0);
    check("rst_gate", voice_gate, 0);
    check("rst_load", voice_load, 0);
    check("rst_ready", ev_ready, 0);
    @(negedge clk) reset = 1'b1;
    #1;
    check("rst_release_ready", ev_ready, 1);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (voice_load != '0 || voice_gate != '0) seen = 1'b1;
    end
    check("rst_no_stale_load", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NV; i++) exp_per[i] = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("reset: period=%0h gate=%b load=%b ready=%b", voice_period, voice_gate, voice_load, ev_ready);
    check("reset_period", voice_period, 0);
    check("reset_gate", voice_gate, 0);
    check("reset_load", voice_load, 0);
    check("reset_steal", steal_evt, 0);
    check("reset_ready", ev_ready, 0);
    @(negedge clk) reset = 1'b1;

    reset_mid_div();

    note_on(7'd69, 0, 1'b0);
    exp_per[0] = 32'd113636;
    check("p69", voice_period, exp_periods());
    check("g69", voice_gate, 4'b0001);

    note_on(7'd57, 1, 1'b0);
    exp_per[1] = 32'd227272;
    note_on(7'd81, 2, 1'b0);
    exp_per[2] = 32'd56818;
    note_on(7'd45, 3, 1'b0);
    exp_per[3] = 32'd454545;
    check("p_four", voice_period, exp_periods());
    check("g_four", voice_gate, 4'b1111);

    // all held: oldest (voice 0) is stolen
    note_on(7'd60, 0, 1'b1);
    exp_per[0] = 32'd191112;
    check("p_steal", voice_period, exp_periods());
    check("g_steal", voice_gate, 4'b1111);

    note_off(7'd57);
    check("g_off57", voice_gate, 4'b1101);
    check("p_off57_kept", voice_period, exp_periods());

    note_on(7'd72, 1, 1'b0);
    exp_per[1] = 32'd95556;
    check("p72", voice_period, exp_periods());
    check("g72", voice_gate, 4'b1111);

    note_off(7'd99);
    check("g_off99", voice_gate, 4'b1111);
    check("p_off99", voice_period, exp_periods());

    // retrigger of a held note
    note_on(7'd81, 2, 1'b0);
    check("p_retrig", voice_period, exp_periods());
    check("g_retrig", voice_gate, 4'b1111);

    // ranks now 2,1,0,3 -> voice 3 is oldest
    note_on(7'd40, 3, 1'b1);
    exp_per[3] = 32'd606745;
    check("p40", voice_period, exp_periods());

    note_off(7'd60);
    check("g_off60", voice_gate, 4'b1110);

    note_on(7'd127, 0, 1'b0);
    exp_per[0] = 32'd3986;
    check("p127", voice_period, exp_periods());

    note_off(7'd127);
    check("g_off127", voice_gate, 4'b1110);
    check("p_off127_kept", voice_period, exp_periods());

    note_on(7'd0, 0, 1'b0);
    exp_per[0] = 32'd6115610;
    check("p0", voice_period, exp_periods());
    check("g0", voice_gate, 4'b1111);

    reset_mid_div();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice controller sitting in front of NUM_VOICES triangle_wave_gen instances.
- Accepts note-on/note-off events over a valid/ready handshake and converts MIDI note numbers to oscillator periods.
- Assigns each note to a voice: retriggers a voice already holding the note, otherwise the lowest free voice, otherwise steals the least-recently-assigned voice.
- Drives per-voice period, gate and a load pulse that retriggers the generator.

Parameters:
NUM_VOICES, 4, number of oscillator voices managed (2..8)
NOTE_W, 7, MIDI note number width
PERIOD_W, 32, per-voice period width in clk cycles

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ev_valid  input  1  event present
ev_ready  output  1  block can accept an event this cycle
ev_on  input  1  1 = note-on, 0 = note-off
ev_note  input  NOTE_W  MIDI note number (0..127)
voice_period  output  NUM_VOICES*PERIOD_W  packed per-voice period; voice i occupies bits [i*PERIOD_W +: PERIOD_W]
voice_gate  output  NUM_VOICES  per-voice gate; 1 = note held
voice_load  output  NUM_VOICES  one-cycle pulse; the generator restarts with the new period
steal_evt  output  1  one-cycle pulse when a held voice was stolen

Behaviour:
- Reset (reset=0, asynchronous):
  - voice_period, voice_gate, voice_load and steal_evt all go to 0; ev_ready=0.
  - Stored notes are cleared to 0.
  - Age ranks initialise to rank[i]=i, so voice NUM_VOICES-1 is the oldest.
  - FSM goes to IDLE. An in-flight event is discarded.
- FSM states: IDLE, DIV, ALLOC.
- IDLE:
  - ev_ready=1. Accept when ev_valid && ev_ready.
  - On acceptance: latch ev_on and ev_note, set rem=ev_note and oct=0.
  - Next state is DIV for note-on, ALLOC for note-off.
- DIV:
  - ev_ready=0.
  - Each cycle: if rem>=12 then rem-=12 and oct+=1; otherwise go to ALLOC.
- ALLOC:
  - ev_ready=0. Registers update on the exiting edge; next state is IDLE.
- Latency:
  - Note-on outputs change at edge floor(note/12)+2 after the acceptance edge.
  - Note-off outputs change 1 edge after acceptance.
  - ev_ready is high again in the cycle after that update.
- Period: period = BASE_PERIOD[rem] >> oct, computed combinationally.
  - BASE_PERIOD is the 12-entry table for MIDI octave 0 at a 50 MHz clk.
  - Required anchor: BASE_PERIOD[9] = 3636364.
  - Truncate on shift. Zero-extend to PERIOD_W.
- Note-on allocation, in priority order:
  1. A gated voice whose stored note equals ev_note: retrigger it.
  2. Otherwise, the lowest-index voice with gate=0.
  3. Otherwise, the voice with the highest rank (steal); steal_evt pulses.
- Note-on writes to the chosen voice v:
  - period[v] = computed period, note[v] = ev_note, gate[v] = 1.
  - voice_load[v] pulses for exactly one cycle, the cycle after the update edge.
- Age ranks: the chosen voice gets rank 0. Every voice whose rank was below v's old rank increments by 1. Ranks remain a permutation of 0..NUM_VOICES-1.
- Note-off:
  - Find the lowest-index gated voice whose note equals ev_note; clear its gate.
  - Period and note are retained so the envelope can release.
  - No load pulse and no rank change.
  - If no voice matches, the event is consumed with no output change.
- One event in flight at a time. ev_valid while ev_ready=0 is ignored, and the upstream holds the event.
- Ungated voices keep their last period.
- Retrigger of the same note does not change which other voices are gated.

Decomposition:
- Shared package synth_pkg holds:
  - the BASE_PERIOD[0:11] constant table;
  - the FSM state encoding for IDLE/DIV/ALLOC;
  - the default NUM_VOICES, NOTE_W and PERIOD_W constants.
- Sub-module note_period_rom: combinational (rem, oct) -> period lookup plus shift, reused later by the arpeggiator.
- Allocation search and rank update stay in voice_allocator.

Test Plan:
- Reset low mid-DIV with note 100 in flight -> all outputs 0 immediately; after release, ev_ready=1 and no load pulse occurs.
- Note-on 69 from reset -> voice 0: period=113636, gate=1; voice_load=0001 for one cycle, 7 edges after acceptance; ev_ready low during processing.
- Note-on 57, 81, 45 after 69 -> voices 1, 2, 3 with periods 227272, 56818, 454545; voice_gate=1111.
- Fifth note-on 60 with all voices gated -> voice 0 stolen (rank 3); steal_evt pulses; voice 0 note becomes 60; voice 1 becomes the next oldest.
- Note-off 57 -> voice_gate[1]=0 with period 227272 kept; a following note-on 72 lands on voice 1 with no steal_evt.
- Note-off 99 (unheld) -> no output change, ev_ready back after 2 cycles. Note-on 81 while 81 is held -> voice 2 retriggered, load pulse 0100, gates otherwise unchanged.
